// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle CPU control path: opcodes, functs,
// FSM state encoding, ALU operation codes and datapath mux select codes.
// Instruction classification record produced by instr_class.
package cpu_defs;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // PC source select
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  // Register destination select
  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  // Register write-data select
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic is_lw;
    logic is_sw;
    logic is_j;
    logic is_jal;
    logic is_bne;
    logic is_jr;
    logic is_rtype;
    logic is_imm;
    logic legal;
  } iclass_t;

endpackage

// File: rtl/instr_class.sv
// Combinational instruction classifier: opcode/funct -> one-hot class flags.
// is_rtype covers R-type arithmetic (ADD/SUB/SLT) only; JR has its own flag.
// legal is set for exactly the supported instructions.
module instr_class
  import cpu_defs::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  output iclass_t        cls
);

  // Decode opcode (and funct for R-type) into class flags
  always_comb begin
    cls = '0;
    case (opcode)
      OP_LW:            cls.is_lw  = 1'b1;
      OP_SW:            cls.is_sw  = 1'b1;
      OP_J:             cls.is_j   = 1'b1;
      OP_JAL:           cls.is_jal = 1'b1;
      OP_BNE:           cls.is_bne = 1'b1;
      OP_ADDI, OP_XORI: cls.is_imm = 1'b1;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: cls.is_rtype = 1'b1;
          FN_JR:                  cls.is_jr    = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    cls.legal = cls.is_lw | cls.is_sw | cls.is_j | cls.is_jal | cls.is_bne |
                cls.is_jr | cls.is_rtype | cls.is_imm;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Datapath strobes are combinational from state and instruction fields and
// forced low while reset is high; memory states wait on mem_ready.
module multicycle_control
  import cpu_defs::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              reg_we,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              ext_sel,
  output logic              illegal
);

  state_t  state;
  state_t  state_nxt;
  logic    illegal_q;
  iclass_t cls;
  logic    is_xori;

  instr_class #(.OPW(OPW)) u_instr_class (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  assign is_xori = (opcode == OP_XORI);

  // State register; illegal is set on entry to TRAP so it tracks the trap state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = M2R_ALU;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOPW'(ALU_ADD);
    ext_sel    = 1'b0;
    illegal    = illegal_q;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          pc_src    = PC_PLUS4;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // Extender samples ext_sel at the end of DECODE; it is held through the instruction.
        ext_sel = is_xori;
        if (!cls.legal) begin
          state_nxt = S_TRAP;
        end else if (cls.is_j) begin
          pc_we     = 1'b1;
          pc_src    = PC_JUMP;
          state_nxt = S_FETCH;
        end else if (cls.is_jal) begin
          pc_we      = 1'b1;
          pc_src     = PC_JUMP;
          reg_we     = 1'b1;
          reg_dst    = DST_R31;
          mem_to_reg = M2R_PC4;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        ext_sel = is_xori;
        if (cls.is_lw || cls.is_sw) begin
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOPW'(ALU_ADD);
          state_nxt = S_MEM;
        end else if (cls.is_imm) begin
          alu_src_b = SRCB_IMM;
          alu_op    = is_xori ? ALUOPW'(ALU_XOR) : ALUOPW'(ALU_ADD);
          state_nxt = S_WB;
        end else if (cls.is_rtype) begin
          alu_src_b = SRCB_REG;
          case (funct)
            FN_SUB:  alu_op = ALUOPW'(ALU_SUB);
            FN_SLT:  alu_op = ALUOPW'(ALU_SLT);
            default: alu_op = ALUOPW'(ALU_ADD);
          endcase
          state_nxt = S_WB;
        end else if (cls.is_bne) begin
          alu_op = ALUOPW'(ALU_SUB);
          if (!alu_zero) begin
            pc_we  = 1'b1;
            pc_src = PC_BRANCH;
          end
          state_nxt = S_FETCH;
        end else if (cls.is_jr) begin
          pc_we     = 1'b1;
          pc_src    = PC_REG;
          state_nxt = S_FETCH;
        end else begin
          // Only reachable if the opcode changed after DECODE
          state_nxt = S_TRAP;
        end
      end
      S_MEM: begin
        ext_sel = is_xori;
        mem_req = 1'b1;
        mem_we  = cls.is_sw;
        if (mem_ready) state_nxt = cls.is_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        ext_sel    = is_xori;
        reg_we     = 1'b1;
        reg_dst    = cls.is_rtype ? DST_RD : DST_RT;
        mem_to_reg = cls.is_lw ? M2R_MEM : M2R_ALU;
        state_nxt  = S_FETCH;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = '0;
      reg_we     = 1'b0;
      reg_dst    = '0;
      mem_to_reg = '0;
      alu_src_b  = '0;
      alu_op     = '0;
      ext_sel    = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
